uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
//  Parametrised UART transmitter with a TX FIFO, for use behind transmitter_receiver in place of
//  the fixed 8N1 transmitter. Data width, FIFO depth and clock rate are generic. Parity
//  (none/even/odd) and stop bits (1/2) are selectable at run time. Back-to-back frames go out
//  with no idle gap while the FIFO holds data.
// PARAMETERS
//  CLK_FREQ    50_000_000  clk frequency in Hz
//  DATA_W      8           data bits per frame, legal 5..9
//  FIFO_DEPTH  4           FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1                      single system clock, rising edge
//  reset        in   1                      asynchronous, active-low
//  baud_select  in   3                      000..111 = 300,1200,4800,9600,19200,38400,57600,115200 baud
//  parity_mode  in   2                      00 none, 01 even, 10 odd, 11 none (reserved)
//  two_stop     in   1                      1 = two stop bits
//  Tx_EN        in   1                      enables frame start
//  Tx_WR        in   1                      write strobe, one word per cycle high
//  Tx_DATA      in   DATA_W                 word to enqueue
//  TxD          out  1                      serial line, idle high
//  Tx_BUSY      out  1                      FSM not IDLE or FIFO not empty
//  Tx_FULL      out  1                      FIFO full
//  Tx_EMPTY     out  1                      FIFO empty
//  Tx_LEVEL     out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  Tx_OVERFLOW  out  1                      1-cycle pulse when a write is dropped
// BEHAVIOUR
//  Reset (reset=0, async): TxD=1, Tx_BUSY=0, Tx_FULL=0, Tx_EMPTY=1, Tx_LEVEL=0, Tx_OVERFLOW=0.
//   FIFO and FSM cleared. A reset mid-frame aborts the frame; TxD returns to 1 immediately.
//  Baud: DIV = round(CLK_FREQ/(16*rate)). A 16x tick fires every DIV cycles.
//   One bit = 16 ticks = 16*DIV clk cycles (115200 @50MHz: DIV=27, 432 cycles/bit).
//  FIFO: write accepted when Tx_WR=1 and Tx_FULL=0. Full is evaluated before any same-cycle pop.
//   A write while full is dropped and pulses Tx_OVERFLOW. Write+pop in the same cycle leaves
//   Tx_LEVEL unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START directly.
//   IDLE: if Tx_EN and !Tx_EMPTY, pop the head word into the shifter. On the same edge, latch
//    baud_select, parity_mode and two_stop, clear the baud and tick counters, and go to START.
//   START: TxD=0 for 1 bit.
//   DATA: DATA_W bits, LSB first.
//   PARITY: skipped when the mode is none. Even: bit = ^data. Odd: bit = ~^data.
//   STOP: TxD=1 for 1 or 2 bits. At the end of STOP, if Tx_EN and !Tx_EMPTY, pop and go
//    straight to START (no idle bit); otherwise go to IDLE.
//  Latency: Tx_WR on edge n (idle, empty, Tx_EN=1) -> word in FIFO after n -> popped on
//   edge n+1 -> TxD falls after edge n+1.
//  Tx_EN=0 mid-frame: the current frame completes and no further pop occurs. FIFO writes are
//   still accepted.
//  Config inputs changing mid-frame have no effect until the next frame start.
//  Baud counter runs only outside IDLE, so the start bit lasts exactly 16*DIV cycles.
// TESTING
//  1 Hold reset=0 for 100ns, then release -> all outputs at reset values; TxD=1 while idle.
//  2 115200 baud, even parity, 1 stop, write 8'h94 -> TxD = 0,0,0,1,0,1,0,0,1,P=1,1;
//    each bit 432 cycles; Tx_BUSY falls 4752 cycles after TxD falls.
//  3 DEPTH=4, 6 writes on consecutive cycles (0x01..0x06) -> first 5 accepted, Tx_LEVEL peaks
//    at 4, Tx_FULL=1, 6th write pulses Tx_OVERFLOW once; 5 frames sent with no idle gap.
//  4 DATA_W=7, odd parity, two_stop=1, write 7'h55 -> 11-bit frame with P=1 and 2 stop bits.
//  5 reset=0 halfway through the DATA bits, with 2 words queued -> TxD=1 at once,
//    Tx_LEVEL=0, no frame after release.
//  6 Tx_EN=0, write 3 words -> Tx_LEVEL=3, TxD stays 1; set Tx_EN=1 -> 3 frames back-to-back.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a small TX FIFO; runtime parity (none/even/odd) and 1/2 stop bits.
// Latency: a word written into an empty FIFO is popped on the next edge and TxD falls after it.
// Backpressure: Tx_FULL blocks writes; a write while full is dropped and pulses Tx_OVERFLOW.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   baud_select       000..111 = 300,1200,4800,9600,19200,38400,57600,115200 baud
//   parity_mode       00/11 none, 01 even, 10 odd
//   two_stop          1 = two stop bits
//   Tx_EN             allows a new frame to start
//   Tx_WR, Tx_DATA    enqueue one word per cycle
//   TxD               serial line, idle high
//   Tx_BUSY           frame in progress or FIFO holding data
//   Tx_FULL/EMPTY     FIFO status
//   Tx_LEVEL          FIFO occupancy
//   Tx_OVERFLOW       one-cycle pulse after a dropped write
module uart_tx_fifo_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    baud_select,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          Tx_EN,
    input  logic                          Tx_WR,
    input  logic [DATA_W-1:0]             Tx_DATA,
    output logic                          TxD,
    output logic                          Tx_BUSY,
    output logic                          Tx_FULL,
    output logic                          Tx_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   Tx_LEVEL,
    output logic                          Tx_OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Rounded divider for the 16x oversampling tick, never below one cycle.
    function automatic int div_of(input int rate);
        int d;
        d = (CLK_FREQ + 8 * rate) / (16 * rate);
        return (d < 1) ? 1 : d;
    endfunction

    localparam int DIV_MAX = div_of(300);
    localparam int DW      = $clog2(DIV_MAX + 1);

    function automatic logic [DW-1:0] div_sel(input logic [2:0] sel);
        logic [DW-1:0] d;
        case (sel)
            3'd0:    d = DW'(div_of(300));
            3'd1:    d = DW'(div_of(1200));
            3'd2:    d = DW'(div_of(4800));
            3'd3:    d = DW'(div_of(9600));
            3'd4:    d = DW'(div_of(19200));
            3'd5:    d = DW'(div_of(38400));
            3'd6:    d = DW'(div_of(57600));
            default: d = DW'(div_of(115200));
        endcase
        return d;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              ovf;
    logic              wr_acc;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign Tx_FULL     = (count == LW'(FIFO_DEPTH));
    assign Tx_EMPTY    = (count == '0);
    assign Tx_LEVEL    = count;
    assign Tx_OVERFLOW = ovf;
    // Full is the registered state, so a pop in the same cycle does not free a slot.
    assign wr_acc      = Tx_WR && !Tx_FULL;
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= Tx_DATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= Tx_WR && Tx_FULL;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // ----------------------------------------------------------- FSM
    state_t            state;
    logic              txd_q;
    logic [DATA_W-1:0] shifter;
    logic              par_bit;
    logic              par_en_q;
    logic              two_stop_q;
    logic              stop_idx;
    logic [BW-1:0]     bit_idx;
    logic [DW-1:0]     div_q;
    logic [DW-1:0]     baud_cnt;
    logic [3:0]        tick_cnt;
    logic              baud_tick;
    logic              bit_done;
    logic              start_ok;
    logic              last_stop;

    assign baud_tick = (baud_cnt == div_q - DW'(1));
    assign bit_done  = baud_tick && (tick_cnt == 4'd15);
    assign start_ok  = Tx_EN && !Tx_EMPTY;
    assign last_stop = !(two_stop_q && !stop_idx);

    // A frame starts from IDLE, or straight from the end of the last stop bit.
    always_comb begin
        pop = 1'b0;
        if (state == S_IDLE) begin
            pop = start_ok;
        end else if (state == S_STOP && bit_done && last_stop) begin
            pop = start_ok;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = (state != S_IDLE) || !Tx_EMPTY;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            txd_q      <= 1'b1;
            shifter    <= '0;
            par_bit    <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx   <= 1'b0;
            bit_idx    <= '0;
            div_q      <= div_sel(3'd7);
            baud_cnt   <= '0;
            tick_cnt   <= '0;
        end else if (pop) begin
            // Frame configuration is captured here and held for the whole frame.
            shifter    <= head;
            par_bit    <= (parity_mode == 2'b10) ? ~^head : ^head;
            par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            two_stop_q <= two_stop;
            div_q      <= div_sel(baud_select);
            baud_cnt   <= '0;
            tick_cnt   <= '0;
            txd_q      <= 1'b0;
            state      <= S_START;
        end else if (state == S_IDLE) begin
            txd_q <= 1'b1;
        end else begin
            if (baud_tick) begin
                baud_cnt <= '0;
                tick_cnt <= tick_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + DW'(1);
            end
            if (bit_done) begin
                case (state)
                    S_START: begin
                        txd_q   <= shifter[0];
                        shifter <= shifter >> 1;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_idx == BW'(DATA_W - 1)) begin
                            stop_idx <= 1'b0;
                            if (par_en_q) begin
                                txd_q <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                txd_q <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            txd_q   <= shifter[0];
                            shifter <= shifter >> 1;
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                    S_PARITY: begin
                        txd_q    <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= S_STOP;
                    end
                    S_STOP: begin
                        txd_q <= 1'b1;
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        txd_q <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: table of single frames plus hand-written multi-cycle sequences.
// Expected frames are queued when words are written and compared as a line monitor decodes TxD.
// Two instances: 8-bit data (most sequences) and 7-bit data (odd parity / two stop bits).
module tb_uart_tx_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] baud_select = 3'd7;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       tx_en = 1'b0;
    logic       wr8 = 1'b0;
    logic       wr7 = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       txd8, busy8, full8, empty8, ovf8;
    logic [2:0] level8;
    logic       txd7, busy7, full7, empty7, ovf7;
    logic [2:0] level7;

    always #5ns clk = ~clk;

    uart_tx_fifo_param #(.CLK_FREQ(50_000_000), .DATA_W(8), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(rst_n), .baud_select(baud_select), .parity_mode(parity_mode),
        .two_stop(two_stop), .Tx_EN(tx_en), .Tx_WR(wr8), .Tx_DATA(tx_data),
        .TxD(txd8), .Tx_BUSY(busy8), .Tx_FULL(full8), .Tx_EMPTY(empty8),
        .Tx_LEVEL(level8), .Tx_OVERFLOW(ovf8)
    );

    uart_tx_fifo_param #(.CLK_FREQ(50_000_000), .DATA_W(7), .FIFO_DEPTH(4)) u_dut7 (
        .clk(clk), .reset(rst_n), .baud_select(baud_select), .parity_mode(parity_mode),
        .two_stop(two_stop), .Tx_EN(tx_en), .Tx_WR(wr7), .Tx_DATA(tx_data[6:0]),
        .TxD(txd7), .Tx_BUSY(busy7), .Tx_FULL(full7), .Tx_EMPTY(empty7),
        .Tx_LEVEL(level7), .Tx_OVERFLOW(ovf7)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    // bits[i] is the i-th bit on the line, start bit first.
    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          period;
        bit          b2b;
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_sel = 1'b0;
    bit   mon_busy = 1'b0;
    int   rst_cnt = 0;
    logic cur_txd;

    assign cur_txd = mon_sel ? txd7 : txd8;

    always @(negedge rst_n) rst_cnt++;

    task automatic push_exp(input logic [11:0] bits, input int nbits, input int period,
                            input bit b2b, input bit abort);
        exp_t e;
        e.bits = bits;
        e.nbits = nbits;
        e.period = period;
        e.b2b = b2b;
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        int   gap;
        int   snap;
        bit   ab;
        @(negedge clk);
        forever begin
            gap = 0;
            while (cur_txd !== 1'b0) begin
                @(negedge clk);
                gap++;
            end
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_frame: got a start bit, expected an idle line");
                while (cur_txd === 1'b0) @(negedge clk);
            end else begin
                e = exp_q.pop_front();
                snap = rst_cnt;
                ab = 1'b0;
                if (e.b2b) chk("b2b_gap", gap, 0);
                for (int i = 0; i < e.nbits; i++) begin
                    repeat ((i == 0) ? e.period / 2 : e.period) @(negedge clk);
                    if (rst_cnt != snap) begin
                        ab = 1'b1;
                        break;
                    end
                    chk($sformatf("frame_bit%0d", i), cur_txd, e.bits[i]);
                end
                chk("frame_abort", ab, e.abort);
                if (!ab) repeat (e.period - e.period / 2) @(negedge clk);
            end
            mon_busy = 1'b0;
        end
    end

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || mon_busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain", (exp_q.size() == 0 && !mon_busy), 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_txd"}, txd8, 1);
        chk({tag, "_busy"}, busy8, 0);
        chk({tag, "_full"}, full8, 0);
        chk({tag, "_empty"}, empty8, 1);
        chk({tag, "_level"}, level8, 0);
        chk({tag, "_ovf"}, ovf8, 0);
        chk({tag, "_txd7"}, txd7, 1);
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        tstop;
        logic [2:0]  baud;
        logic [11:0] bits;
        int          nbits;
        int          period;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt;
        int peak;
        int ovf_cnt;
        int zeros;
        bit full_seen;
        logic [7:0] d;

        // 115200 baud at 50 MHz: 27 cycles/tick, 432 cycles/bit; 57600: 54, 864.
        vecs[0] = '{8'h94, 2'b01, 1'b0, 3'd7, {1'b0, 2'b11, 8'h94, 1'b0}, 11, 432};
        vecs[1] = '{8'h3C, 2'b00, 1'b1, 3'd6, {1'b0, 2'b11, 8'h3C, 1'b0}, 11, 864};
        vecs[2] = '{8'hA7, 2'b10, 1'b0, 3'd7, {1'b0, 1'b1, 1'b0, 8'hA7, 1'b0}, 11, 432};
        vecs[3] = '{8'h00, 2'b11, 1'b0, 3'd7, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 432};
        vecs[4] = '{8'hFF, 2'b01, 1'b1, 3'd7, {1'b1, 1'b1, 1'b0, 8'hFF, 1'b0}, 12, 432};

        // Reset values, during and after reset.
        rst_n = 1'b0;
        #50ns;
        check_idle("in_reset");
        #50ns;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        // Single frames: latency, frame contents, exact frame length.
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            baud_select = vecs[r].baud;
            parity_mode = vecs[r].pmode;
            two_stop = vecs[r].tstop;
            tx_en = 1'b1;
            tx_data = vecs[r].data;
            push_exp(vecs[r].bits, vecs[r].nbits, vecs[r].period, 1'b0, 1'b0);
            wr8 = 1'b1;
            @(negedge clk);
            wr8 = 1'b0;
            chk($sformatf("v%0d_lat0_txd", r), txd8, 1);
            chk($sformatf("v%0d_lat0_level", r), level8, 1);
            @(negedge clk);
            chk($sformatf("v%0d_lat1_txd", r), txd8, 0);
            chk($sformatf("v%0d_lat1_level", r), level8, 0);
            chk($sformatf("v%0d_lat1_busy", r), busy8, 1);
            cnt = 0;
            while (busy8 && cnt < vecs[r].nbits * vecs[r].period + 100) begin
                @(negedge clk);
                cnt++;
            end
            chk($sformatf("v%0d_busy_len", r), cnt, vecs[r].nbits * vecs[r].period);
            drain(2000);
        end

        // Six writes on consecutive cycles into a depth-4 FIFO.
        @(negedge clk);
        baud_select = 3'd7;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        tx_en = 1'b1;
        peak = 0;
        ovf_cnt = 0;
        full_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = 8'(i + 1);
            tx_data = d;
            if (i < 5) push_exp({2'b00, 1'b1, d, 1'b0}, 10, 432, (i > 0), 1'b0);
            wr8 = 1'b1;
            @(negedge clk);
            if (int'(level8) > peak) peak = int'(level8);
            if (full8) full_seen = 1'b1;
            if (ovf8) ovf_cnt++;
        end
        wr8 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ovf8) ovf_cnt++;
        end
        chk("burst_peak_level", peak, 4);
        chk("burst_full_seen", full_seen, 1);
        chk("burst_ovf_pulses", ovf_cnt, 1);
        drain(5 * 10 * 432 + 1000);
        chk("burst_end_empty", empty8, 1);
        chk("burst_end_busy", busy8, 0);

        // 7-bit data, odd parity, two stop bits.
        @(negedge clk);
        mon_sel = 1'b1;
        parity_mode = 2'b10;
        two_stop = 1'b1;
        tx_data = 8'h55;
        push_exp({1'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11, 432, 1'b0, 1'b0);
        wr7 = 1'b1;
        @(negedge clk);
        wr7 = 1'b0;
        drain(11 * 432 + 1000);
        chk("d7_idle_busy", busy7, 0);
        mon_sel = 1'b0;

        // Reset in the middle of the data bits with two words still queued.
        @(negedge clk);
        parity_mode = 2'b00;
        two_stop = 1'b0;
        push_exp({2'b00, 1'b1, 8'hC3, 1'b0}, 10, 432, 1'b0, 1'b1);
        tx_data = 8'hC3;
        wr8 = 1'b1;
        @(negedge clk);
        tx_data = 8'h5A;
        @(negedge clk);
        tx_data = 8'h7E;
        @(negedge clk);
        wr8 = 1'b0;
        repeat (5 * 432) @(negedge clk);
        chk("mid_level_before", level8, 2);
        #1ns;
        rst_n = 1'b0;
        #1ns;
        chk("mid_rst_txd", txd8, 1);
        chk("mid_rst_level", level8, 0);
        chk("mid_rst_empty", empty8, 1);
        chk("mid_rst_busy", busy8, 0);
        #98ns;
        rst_n = 1'b1;
        zeros = 0;
        repeat (3000) begin
            @(negedge clk);
            if (txd8 !== 1'b1) zeros++;
        end
        chk("post_rst_line_low", zeros, 0);
        chk("post_rst_level", level8, 0);
        drain(10);

        // Writes held while disabled, then released back-to-back.
        @(negedge clk);
        tx_en = 1'b0;
        parity_mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 8'h11 : (i == 1) ? 8'h23 : 8'h37;
            tx_data = d;
            push_exp({1'b0, 1'b1, ^d, d, 1'b0}, 11, 432, (i > 0), 1'b0);
            wr8 = 1'b1;
            @(negedge clk);
        end
        wr8 = 1'b0;
        zeros = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd8 !== 1'b1) zeros++;
        end
        chk("hold_level", level8, 3);
        chk("hold_line_low", zeros, 0);
        chk("hold_busy", busy8, 1);
        tx_en = 1'b1;
        drain(3 * 11 * 432 + 1000);
        chk("hold_end_empty", empty8, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
